ysyx_22050710_axil_arbiter: RTL and testbench
=============================================

Name: ysyx_22050710_axil_arbiter

Overview:
Two-to-one AXI-lite arbiter that sits directly upstream of the AXI-lite SRAM wrapper. It merges the IFU read-only master (port s0) and the LSU read/write master (port s1) onto one AXI-lite master port (m) that feeds the SRAM slave. Reads are arbitrated round-robin. Writes come only from the LSU and are sequenced AW then W then B, matching the slave's ordering requirement.

Parameters:
DATA_WIDTH, 64, data bus width in bits
ADDR_WIDTH, 32, address bus width in bits
STRB_WIDTH, DATA_WIDTH/8, write strobe width

Ports:
i_aclk  in  1  clock
i_arsetn  in  1  reset, asynchronous, active-low
i_s0_arvalid / o_s0_arready  in/out  1/1  IFU AR handshake
i_s0_araddr / i_s0_arprot  in  ADDR_WIDTH/3  IFU AR payload
o_s0_rvalid / i_s0_rready  out/in  1/1  IFU R handshake
o_s0_rdata / o_s0_rresp  out  DATA_WIDTH/2  IFU R payload
i_s1_arvalid, o_s1_arready, i_s1_araddr, i_s1_arprot  mixed  1,1,ADDR_WIDTH,3  LSU AR channel
o_s1_rvalid, i_s1_rready, o_s1_rdata, o_s1_rresp  mixed  1,1,DATA_WIDTH,2  LSU R channel
i_s1_awvalid, o_s1_awready, i_s1_awaddr, i_s1_awprot  mixed  1,1,ADDR_WIDTH,3  LSU AW channel
i_s1_wvalid, o_s1_wready, i_s1_wdata, i_s1_wstrb  mixed  1,1,DATA_WIDTH,STRB_WIDTH  LSU W channel
o_s1_bvalid, i_s1_bready, o_s1_bresp  mixed  1,1,2  LSU B channel
o_m_ar*, i_m_r*, o_m_aw*, o_m_w*, i_m_b*  mixed  same widths  master port to SRAM wrapper. Directions are mirrored from the upstream ports.

Behaviour:
Clocking and reset:
- One clock domain, i_aclk. Reset is asynchronous and active-low on i_arsetn.

Read FSM (states R_IDLE, R_ADDR, R_DATA):
- R_IDLE: winner is selected combinationally from the asserted arvalids.
  - If both are valid, the winner is the source that is not last_grant.
  - The winner's arready = 1. The loser's arready = 0. Both arreadys are 0 when no arvalid is asserted.
  - On upstream ar_fire: latch grant, araddr and arprot, then go to R_ADDR.
- R_ADDR: o_m_arvalid = 1, driven by the latched registers. On m ar_fire, go to R_DATA.
- R_DATA: the granted source's rvalid/rdata/rresp are connected straight through from the master port, and i_m_rready = the granted source's rready.
  - The non-granted source sees rvalid = 0 and rdata/rresp = 0.
  - On r_fire: last_grant <= grant, go to R_IDLE.
- Latency with an always-ready SRAM:
  - Upstream ar_fire at cycle N.
  - o_m_arvalid at N+1.
  - Upstream rvalid at N+2. The SRAM returns data one cycle after its AR fire, and R is combinational pass-through.
- Only one read is outstanding at a time. No arready is asserted outside R_IDLE.
- rresp is forwarded verbatim, including non-OKAY values.

Write FSM (states W_IDLE, W_AW, W_W, W_B):
- W_IDLE: o_s1_awready = 1. On aw_fire, latch awaddr and awprot, go to W_AW.
- W_AW: o_m_awvalid = 1. On m aw_fire, go to W_W.
- W_W: W channel is combinational pass-through between s1 and m: wvalid, wready, wdata, wstrb. On m w_fire, go to W_B.
- W_B: B channel is pass-through. On b_fire, go to W_IDLE.
- Outside W_W, o_m_wvalid = 0 and o_s1_wready = 0. Outside W_B, o_s1_bvalid = 0 and i_m_bready is driven 0.
- If W is presented before AW, it is held by the LSU until W_W.

Concurrency:
- The read and write FSMs are independent and may be active in the same cycle.
- Read-after-write ordering to the same address is the LSU's responsibility: it waits for bresp before issuing the read.

Reset values:
- Both FSMs are IDLE. last_grant = s1, so s0 wins the first simultaneous request.
- Latched registers are 0. All m-side valids are 0 and all upstream rvalid/bvalid are 0. o_s1_awready = 1.

Reset mid-operation:
- Asynchronous assertion forces IDLE immediately and drops the in-flight transaction. Valids fall in the same instant.
- The SRAM wrapper shares the reset, so no orphan response is delivered after reset.

Stability:
- o_m_ar* and o_m_aw* payloads are stable from valid until fire, because they come from registers.

Test Plan:
- Single IFU read to 0x8000_0000, SRAM returns 0x1122334455667788 -> o_s0_arready at cycle 0, o_m_arvalid at cycle 1, o_s0_rvalid with that data and rresp = 0 at cycle 2. o_s1_rvalid stays 0.
- s0 and s1 assert arvalid together after reset (0x100, 0x200) -> s0 is granted first with 0x100 on the master. After its r_fire, s1 is granted with 0x200. A second simultaneous pair -> s0 is granted again (round-robin).
- LSU write of 0x80000008, wdata 0xDEADBEEF, wstrb 0x0F, with wvalid raised together with awvalid -> the master sees AW at cycle 1 and W at cycle 2. o_s1_bvalid follows the SRAM's bvalid, and the write FSM returns to W_IDLE after bready.
- IFU read overlapped with an LSU write -> both complete with correct data and bresp, with no cross-channel stall.
- i_s0_rready held low for 3 cycles in R_DATA -> i_m_rready is low and the state is held. A new s1 arvalid during this time is not granted until r_fire.
- i_arsetn pulsed low while in R_DATA and W_B -> all valids drop at once, both FSMs go IDLE, and the next read is granted to s0.

Source files
------------

// File: rtl/ysyx_22050710_axil_arbiter.sv
// rtl/ysyx_22050710_axil_arbiter.sv - two-to-one AXI-lite arbiter (IFU read, LSU read/write) in front of the SRAM wrapper
module ysyx_22050710_axil_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  i_aclk,
    input  logic                  i_arsetn,
    input  logic                  i_s0_arvalid,
    output logic                  o_s0_arready,
    input  logic [ADDR_WIDTH-1:0] i_s0_araddr,
    input  logic [2:0]            i_s0_arprot,
    output logic                  o_s0_rvalid,
    input  logic                  i_s0_rready,
    output logic [DATA_WIDTH-1:0] o_s0_rdata,
    output logic [1:0]            o_s0_rresp,
    input  logic                  i_s1_arvalid,
    output logic                  o_s1_arready,
    input  logic [ADDR_WIDTH-1:0] i_s1_araddr,
    input  logic [2:0]            i_s1_arprot,
    output logic                  o_s1_rvalid,
    input  logic                  i_s1_rready,
    output logic [DATA_WIDTH-1:0] o_s1_rdata,
    output logic [1:0]            o_s1_rresp,
    input  logic                  i_s1_awvalid,
    output logic                  o_s1_awready,
    input  logic [ADDR_WIDTH-1:0] i_s1_awaddr,
    input  logic [2:0]            i_s1_awprot,
    input  logic                  i_s1_wvalid,
    output logic                  o_s1_wready,
    input  logic [DATA_WIDTH-1:0] i_s1_wdata,
    input  logic [STRB_WIDTH-1:0] i_s1_wstrb,
    output logic                  o_s1_bvalid,
    input  logic                  i_s1_bready,
    output logic [1:0]            o_s1_bresp,
    output logic                  o_m_arvalid,
    input  logic                  i_m_arready,
    output logic [ADDR_WIDTH-1:0] o_m_araddr,
    output logic [2:0]            o_m_arprot,
    input  logic                  i_m_rvalid,
    output logic                  o_m_rready,
    input  logic [DATA_WIDTH-1:0] i_m_rdata,
    input  logic [1:0]            i_m_rresp,
    output logic                  o_m_awvalid,
    input  logic                  i_m_awready,
    output logic [ADDR_WIDTH-1:0] o_m_awaddr,
    output logic [2:0]            o_m_awprot,
    output logic                  o_m_wvalid,
    input  logic                  i_m_wready,
    output logic [DATA_WIDTH-1:0] o_m_wdata,
    output logic [STRB_WIDTH-1:0] o_m_wstrb,
    input  logic                  i_m_bvalid,
    output logic                  o_m_bready,
    input  logic [1:0]            i_m_bresp
);

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_ADDR = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_AW   = 2'd1;
    localparam logic [1:0] W_W    = 2'd2;
    localparam logic [1:0] W_B    = 2'd3;

    logic [1:0]            r_state_q, r_state_d;
    logic                  grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [2:0]            arprot_q, arprot_d;

    logic [1:0]            w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [2:0]            awprot_q, awprot_d;

    logic r_idle, r_data, win_s1, up_ar_fire, r_fire;
    logic w_w, w_b;

    // grant = 1 selects s1; on a tie the source that did not win last time goes first
    assign r_idle     = (r_state_q == R_IDLE);
    assign r_data     = (r_state_q == R_DATA);
    assign win_s1     = i_s1_arvalid & (~i_s0_arvalid | ~last_grant_q);
    assign up_ar_fire = r_idle & (i_s0_arvalid | i_s1_arvalid);
    assign r_fire     = i_m_rvalid & o_m_rready;

    assign o_s0_arready = r_idle & i_s0_arvalid & ~win_s1;
    assign o_s1_arready = r_idle & win_s1;

    assign o_m_arvalid = (r_state_q == R_ADDR);
    assign o_m_araddr  = araddr_q;
    assign o_m_arprot  = arprot_q;

    assign o_m_rready  = r_data & (grant_q ? i_s1_rready : i_s0_rready);
    assign o_s0_rvalid = r_data & ~grant_q & i_m_rvalid;
    assign o_s0_rdata  = (r_data & ~grant_q) ? i_m_rdata : '0;
    assign o_s0_rresp  = (r_data & ~grant_q) ? i_m_rresp : 2'b00;
    assign o_s1_rvalid = r_data & grant_q & i_m_rvalid;
    assign o_s1_rdata  = (r_data & grant_q) ? i_m_rdata : '0;
    assign o_s1_rresp  = (r_data & grant_q) ? i_m_rresp : 2'b00;

    always_comb begin
        r_state_d    = r_state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        araddr_d     = araddr_q;
        arprot_d     = arprot_q;
        case (r_state_q)
            R_IDLE: if (up_ar_fire) begin
                grant_d   = win_s1;
                araddr_d  = win_s1 ? i_s1_araddr : i_s0_araddr;
                arprot_d  = win_s1 ? i_s1_arprot : i_s0_arprot;
                r_state_d = R_ADDR;
            end
            R_ADDR: if (i_m_arready) r_state_d = R_DATA;
            R_DATA: if (r_fire) begin
                last_grant_d = grant_q;
                r_state_d    = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    assign w_w = (w_state_q == W_W);
    assign w_b = (w_state_q == W_B);

    assign o_s1_awready = (w_state_q == W_IDLE);
    assign o_m_awvalid  = (w_state_q == W_AW);
    assign o_m_awaddr   = awaddr_q;
    assign o_m_awprot   = awprot_q;

    assign o_m_wvalid  = w_w & i_s1_wvalid;
    assign o_s1_wready = w_w & i_m_wready;
    assign o_m_wdata   = i_s1_wdata;
    assign o_m_wstrb   = i_s1_wstrb;

    assign o_s1_bvalid = w_b & i_m_bvalid;
    assign o_m_bready  = w_b & i_s1_bready;
    assign o_s1_bresp  = w_b ? i_m_bresp : 2'b00;

    always_comb begin
        w_state_d = w_state_q;
        awaddr_d  = awaddr_q;
        awprot_d  = awprot_q;
        case (w_state_q)
            W_IDLE: if (i_s1_awvalid) begin
                awaddr_d  = i_s1_awaddr;
                awprot_d  = i_s1_awprot;
                w_state_d = W_AW;
            end
            W_AW:    if (i_m_awready) w_state_d = W_W;
            W_W:     if (i_s1_wvalid & i_m_wready) w_state_d = W_B;
            W_B:     if (i_m_bvalid & i_s1_bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge i_aclk or negedge i_arsetn) begin
        if (!i_arsetn) begin
            r_state_q    <= R_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            araddr_q     <= '0;
            arprot_q     <= 3'b000;
            w_state_q    <= W_IDLE;
            awaddr_q     <= '0;
            awprot_q     <= 3'b000;
        end else begin
            r_state_q    <= r_state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            araddr_q     <= araddr_d;
            arprot_q     <= arprot_d;
            w_state_q    <= w_state_d;
            awaddr_q     <= awaddr_d;
            awprot_q     <= awprot_d;
        end
    end

endmodule

// File: tb/tb_ysyx_22050710_axil_arbiter.sv
// tb/tb_ysyx_22050710_axil_arbiter.sv - self-checking bench for the AXI-lite arbiter with an SRAM slave model
module tb_ysyx_22050710_axil_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        i_s0_arvalid, o_s0_arready, i_s0_rready, o_s0_rvalid;
    logic [31:0] i_s0_araddr;
    logic [2:0]  i_s0_arprot;
    logic [63:0] o_s0_rdata;
    logic [1:0]  o_s0_rresp;
    logic        i_s1_arvalid, o_s1_arready, i_s1_rready, o_s1_rvalid;
    logic [31:0] i_s1_araddr;
    logic [2:0]  i_s1_arprot;
    logic [63:0] o_s1_rdata;
    logic [1:0]  o_s1_rresp;
    logic        i_s1_awvalid, o_s1_awready, i_s1_wvalid, o_s1_wready, o_s1_bvalid, i_s1_bready;
    logic [31:0] i_s1_awaddr;
    logic [2:0]  i_s1_awprot;
    logic [63:0] i_s1_wdata;
    logic [7:0]  i_s1_wstrb;
    logic [1:0]  o_s1_bresp;
    logic        o_m_arvalid, m_arready, m_rvalid, o_m_rready;
    logic [31:0] o_m_araddr;
    logic [2:0]  o_m_arprot;
    logic [63:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        o_m_awvalid, m_awready, o_m_wvalid, m_wready, m_bvalid, o_m_bready;
    logic [31:0] o_m_awaddr;
    logic [2:0]  o_m_awprot;
    logic [63:0] o_m_wdata;
    logic [7:0]  o_m_wstrb;
    logic [1:0]  m_bresp;

    logic [1:0]  rresp_cfg, bresp_cfg;
    logic [31:0] aw_seen;
    logic [63:0] w_seen;
    logic [7:0]  strb_seen;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        src;
        logic [63:0] data;
        logic [1:0]  resp;
    } rd_exp_t;
    rd_exp_t exp_q[$];

    typedef struct {
        logic        src;
        logic [31:0] addr;
        logic [1:0]  resp;
        logic [63:0] exp_data;
    } rd_vec_t;
    rd_vec_t vecs[4];

    ysyx_22050710_axil_arbiter dut (
        .i_aclk(clk), .i_arsetn(rst_n),
        .i_s0_arvalid(i_s0_arvalid), .o_s0_arready(o_s0_arready), .i_s0_araddr(i_s0_araddr),
        .i_s0_arprot(i_s0_arprot), .o_s0_rvalid(o_s0_rvalid), .i_s0_rready(i_s0_rready),
        .o_s0_rdata(o_s0_rdata), .o_s0_rresp(o_s0_rresp),
        .i_s1_arvalid(i_s1_arvalid), .o_s1_arready(o_s1_arready), .i_s1_araddr(i_s1_araddr),
        .i_s1_arprot(i_s1_arprot), .o_s1_rvalid(o_s1_rvalid), .i_s1_rready(i_s1_rready),
        .o_s1_rdata(o_s1_rdata), .o_s1_rresp(o_s1_rresp),
        .i_s1_awvalid(i_s1_awvalid), .o_s1_awready(o_s1_awready), .i_s1_awaddr(i_s1_awaddr),
        .i_s1_awprot(i_s1_awprot), .i_s1_wvalid(i_s1_wvalid), .o_s1_wready(o_s1_wready),
        .i_s1_wdata(i_s1_wdata), .i_s1_wstrb(i_s1_wstrb), .o_s1_bvalid(o_s1_bvalid),
        .i_s1_bready(i_s1_bready), .o_s1_bresp(o_s1_bresp),
        .o_m_arvalid(o_m_arvalid), .i_m_arready(m_arready), .o_m_araddr(o_m_araddr),
        .o_m_arprot(o_m_arprot), .i_m_rvalid(m_rvalid), .o_m_rready(o_m_rready),
        .i_m_rdata(m_rdata), .i_m_rresp(m_rresp),
        .o_m_awvalid(o_m_awvalid), .i_m_awready(m_awready), .o_m_awaddr(o_m_awaddr),
        .o_m_awprot(o_m_awprot), .o_m_wvalid(o_m_wvalid), .i_m_wready(m_wready),
        .o_m_wdata(o_m_wdata), .o_m_wstrb(o_m_wstrb), .i_m_bvalid(m_bvalid),
        .o_m_bready(o_m_bready), .i_m_bresp(m_bresp)
    );

    function automatic logic [63:0] sram_fn(input logic [31:0] a);
        if (a == 32'h8000_0000) return 64'h1122_3344_5566_7788;
        return {~a, a};
    endfunction

    // SRAM slave: always ready, read data one cycle after AR fire, B one cycle after W fire
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rvalid <= 1'b0;
            m_rdata  <= '0;
            m_rresp  <= 2'b00;
            m_bvalid <= 1'b0;
            m_bresp  <= 2'b00;
        end else begin
            if (o_m_arvalid && m_arready) begin
                m_rvalid <= 1'b1;
                m_rdata  <= sram_fn(o_m_araddr);
                m_rresp  <= rresp_cfg;
            end else if (m_rvalid && o_m_rready) begin
                m_rvalid <= 1'b0;
            end
            if (o_m_awvalid && m_awready) aw_seen <= o_m_awaddr;
            if (o_m_wvalid && m_wready) begin
                m_bvalid  <= 1'b1;
                m_bresp   <= bresp_cfg;
                w_seen    <= o_m_wdata;
                strb_seen <= o_m_wstrb;
            end else if (m_bvalid && o_m_bready) begin
                m_bvalid <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic pop_check(input logic src, input logic [63:0] data, input logic [1:0] resp);
        rd_exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected_r src=%0d data=%h required=no response", src, data);
        end else begin
            e = exp_q.pop_front();
            chk("sb_r_src", {63'd0, src}, {63'd0, e.src});
            chk("sb_r_data", data, e.data);
            chk("sb_r_resp", {62'd0, resp}, {62'd0, e.resp});
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (o_s0_rvalid && i_s0_rready) pop_check(1'b0, o_s0_rdata, o_s0_rresp);
                if (o_s1_rvalid && i_s1_rready) pop_check(1'b1, o_s1_rdata, o_s1_rresp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic src, input logic [31:0] addr, input logic [1:0] resp);
        rd_exp_t e;
        e.src  = src;
        e.data = sram_fn(addr);
        e.resp = resp;
        exp_q.push_back(e);
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'h8000_0000, 2'b00, 64'h1122_3344_5566_7788};
        vecs[1] = '{1'b1, 32'h0000_0010, 2'b10, 64'hFFFF_FFEF_0000_0010};
        vecs[2] = '{1'b0, 32'h1234_5678, 2'b11, 64'hEDCB_A987_1234_5678};
        vecs[3] = '{1'b1, 32'hFFFF_FFF8, 2'b00, 64'h0000_0007_FFFF_FFF8};

        i_s0_arvalid = 0; i_s0_araddr = 0; i_s0_arprot = 0; i_s0_rready = 1;
        i_s1_arvalid = 0; i_s1_araddr = 0; i_s1_arprot = 0; i_s1_rready = 1;
        i_s1_awvalid = 0; i_s1_awaddr = 0; i_s1_awprot = 0;
        i_s1_wvalid = 0; i_s1_wdata = 0; i_s1_wstrb = 0; i_s1_bready = 1;
        m_arready = 1; m_awready = 1; m_wready = 1;
        rresp_cfg = 2'b00; bresp_cfg = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        #1;
        chk("rst_s1_awready", {63'd0, o_s1_awready}, 64'd1);
        chk("rst_m_valids", {60'd0, o_m_arvalid, o_m_awvalid, o_m_wvalid, o_m_bready}, 64'd0);
        chk("rst_up_valids", {61'd0, o_s0_rvalid, o_s1_rvalid, o_s1_bvalid}, 64'd0);
        chk("rst_arreadys", {62'd0, o_s0_arready, o_s1_arready}, 64'd0);
        chk("rst_m_araddr", {32'd0, o_m_araddr}, 64'd0);

        // simultaneous requests after reset: s0 first, then s1, then s0 again
        tick();
        i_s0_arvalid = 1; i_s0_araddr = 32'h100; i_s1_arvalid = 1; i_s1_araddr = 32'h200;
        #1;
        chk("rr1_s0_arready", {63'd0, o_s0_arready}, 64'd1);
        chk("rr1_s1_arready", {63'd0, o_s1_arready}, 64'd0);
        push(1'b0, 32'h100, 2'b00);
        tick();
        i_s0_arvalid = 0;
        chk("rr1_m_araddr", {32'd0, o_m_araddr}, 64'h100);
        chk("rr1_s1_blocked", {63'd0, o_s1_arready}, 64'd0);
        tick();
        tick();
        chk("rr2_s1_arready", {63'd0, o_s1_arready}, 64'd1);
        push(1'b1, 32'h200, 2'b00);
        tick();
        i_s1_arvalid = 0;
        chk("rr2_m_araddr", {32'd0, o_m_araddr}, 64'h200);
        tick();
        tick();
        i_s0_arvalid = 1; i_s0_araddr = 32'h300; i_s1_arvalid = 1; i_s1_araddr = 32'h400;
        #1;
        chk("rr3_s0_arready", {63'd0, o_s0_arready}, 64'd1);
        chk("rr3_s1_arready", {63'd0, o_s1_arready}, 64'd0);
        push(1'b0, 32'h300, 2'b00);
        tick();
        i_s0_arvalid = 0; i_s1_arvalid = 0;
        tick();
        tick();

        // single-source reads from the table, fixed latency 0/1/2
        for (int i = 0; i < 4; i++) begin
            rresp_cfg = vecs[i].resp;
            if (vecs[i].src) begin i_s1_arvalid = 1; i_s1_araddr = vecs[i].addr; end
            else begin i_s0_arvalid = 1; i_s0_araddr = vecs[i].addr; end
            #1;
            chk("vec_arready", {62'd0, o_s1_arready, o_s0_arready}, vecs[i].src ? 64'd2 : 64'd1);
            push(vecs[i].src, vecs[i].addr, vecs[i].resp);
            tick();
            chk("vec_busy_arready", {62'd0, o_s1_arready, o_s0_arready}, 64'd0);
            chk("vec_m_arvalid", {63'd0, o_m_arvalid}, 64'd1);
            chk("vec_m_araddr", {32'd0, o_m_araddr}, {32'd0, vecs[i].addr});
            i_s0_arvalid = 0; i_s1_arvalid = 0;
            tick();
            chk("vec_rvalid", {62'd0, o_s1_rvalid, o_s0_rvalid}, vecs[i].src ? 64'd2 : 64'd1);
            chk("vec_rdata", vecs[i].src ? o_s1_rdata : o_s0_rdata, vecs[i].exp_data);
            chk("vec_other_rdata", vecs[i].src ? o_s0_rdata : o_s1_rdata, 64'd0);
            tick();
        end
        rresp_cfg = 2'b00;

        // LSU write with W presented together with AW
        i_s1_awvalid = 1; i_s1_awaddr = 32'h8000_0008; i_s1_wvalid = 1;
        i_s1_wdata = 64'hDEAD_BEEF; i_s1_wstrb = 8'h0F;
        #1;
        chk("wr_awready", {63'd0, o_s1_awready}, 64'd1);
        chk("wr_early_wready", {62'd0, o_s1_wready, o_m_wvalid}, 64'd0);
        tick();
        i_s1_awvalid = 0;
        chk("wr_m_aw", {31'd0, o_m_awvalid, o_m_awaddr}, {31'd0, 1'b1, 32'h8000_0008});
        chk("wr_m_wvalid_c1", {63'd0, o_m_wvalid}, 64'd0);
        tick();
        chk("wr_m_w", {62'd0, o_m_wvalid, o_s1_wready}, 64'd3);
        chk("wr_m_wdata", o_m_wdata, 64'hDEAD_BEEF);
        chk("wr_m_wstrb", {56'd0, o_m_wstrb}, 64'h0F);
        tick();
        i_s1_wvalid = 0;
        chk("wr_bvalid", {63'd0, o_s1_bvalid}, 64'd1);
        chk("wr_m_bready", {63'd0, o_m_bready}, 64'd1);
        tick();
        chk("wr_idle", {62'd0, o_s1_awready, o_s1_bvalid}, 64'd2);
        chk("wr_sram_seen", {aw_seen, w_seen[31:0]}, {32'h8000_0008, 32'hDEAD_BEEF});
        chk("wr_sram_strb", {56'd0, strb_seen}, 64'h0F);

        // R_DATA stall: s0 holds rready low, a pending s1 request must wait
        i_s0_rready = 0; i_s0_arvalid = 1; i_s0_araddr = 32'h500;
        push(1'b0, 32'h500, 2'b00);
        tick();
        i_s0_arvalid = 0;
        tick();
        i_s1_arvalid = 1; i_s1_araddr = 32'h600;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_held", {61'd0, o_s0_rvalid, o_m_rready, o_s1_arready}, 64'd4);
            tick();
        end
        i_s0_rready = 1;
        #1;
        chk("stall_release", {63'd0, o_m_rready}, 64'd1);
        tick();
        chk("stall_s1_granted", {63'd0, o_s1_arready}, 64'd1);
        push(1'b1, 32'h600, 2'b00);
        tick();
        i_s1_arvalid = 0;
        tick();
        tick();

        // IFU read overlapped with LSU write, non-OKAY bresp forwarded
        bresp_cfg = 2'b10;
        i_s0_arvalid = 1; i_s0_araddr = 32'h40;
        i_s1_awvalid = 1; i_s1_awaddr = 32'h88; i_s1_wvalid = 1; i_s1_wdata = 64'h55; i_s1_wstrb = 8'hFF;
        #1;
        chk("ov_readies", {62'd0, o_s0_arready, o_s1_awready}, 64'd3);
        push(1'b0, 32'h40, 2'b00);
        tick();
        i_s0_arvalid = 0; i_s1_awvalid = 0;
        chk("ov_m_valids", {62'd0, o_m_arvalid, o_m_awvalid}, 64'd3);
        tick();
        chk("ov_r_and_w", {62'd0, o_s0_rvalid, o_m_wvalid}, 64'd3);
        tick();
        i_s1_wvalid = 0;
        chk("ov_bresp", {61'd0, o_s1_bvalid, o_s1_bresp}, 64'h6);
        tick();
        chk("ov_done", {61'd0, o_s1_awready, o_s1_bvalid, o_s0_rvalid}, 64'd4);
        bresp_cfg = 2'b00;

        // reset mid-flight with read in R_DATA and write in W_B
        i_s0_rready = 0; i_s1_bready = 0;
        i_s0_arvalid = 1; i_s0_araddr = 32'h700;
        i_s1_awvalid = 1; i_s1_awaddr = 32'h90; i_s1_wvalid = 1;
        push(1'b0, 32'h700, 2'b00);
        tick();
        i_s0_arvalid = 0; i_s1_awvalid = 0;
        tick();
        tick();
        i_s1_wvalid = 0;
        chk("mid_busy", {62'd0, o_s0_rvalid, o_s1_bvalid}, 64'd3);
        #1 rst_n = 0;
        #1;
        chk("mid_valids_drop", {59'd0, o_s0_rvalid, o_s1_bvalid, o_m_arvalid, o_m_awvalid, o_m_wvalid}, 64'd0);
        chk("mid_awready", {63'd0, o_s1_awready}, 64'd1);
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1;
        i_s0_rready = 1; i_s1_bready = 1;
        i_s0_arvalid = 1; i_s0_araddr = 32'h800; i_s1_arvalid = 1; i_s1_araddr = 32'h900;
        #1;
        chk("post_rst_grant", {62'd0, o_s0_arready, o_s1_arready}, 64'd2);
        push(1'b0, 32'h800, 2'b00);
        tick();
        i_s0_arvalid = 0; i_s1_arvalid = 0;
        tick();
        tick();
        tick();
        chk("sb_drained", {32'd0, exp_q.size()}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
